// File: rtl/controle_sequencia_pkg.sv
// Shared constants, state codes and the one-hot address helper for the
// memory-game sequencing controller.
package controle_sequencia_pkg;
  localparam int NUM_POS     = 4;
  localparam int ADDR_W      = NUM_POS;
  localparam int DATA_W      = 4;
  localparam int IDX_W       = $clog2(NUM_POS);
  localparam int T_MOSTRA_DEF = 500;
  localparam int T_PAUSA_DEF  = 250;

  typedef enum logic [2:0] {
    S_INICIAL      = 3'd0,
    S_BUSCA_MOSTRA = 3'd1,
    S_MOSTRA       = 3'd2,
    S_PAUSA        = 3'd3,
    S_ESPERA       = 3'd4,
    S_BUSCA_CMP    = 3'd5,
    S_COMPARA      = 3'd6,
    S_FIM          = 3'd7
  } estado_t;

  function automatic logic [ADDR_W-1:0] onehot(input logic [IDX_W-1:0] i);
    return ADDR_W'(1) << i;
  endfunction
endpackage

// File: rtl/controle_sequencia_if.sv
// ROM bus and player-move signals between the controller and its surroundings.
interface controle_sequencia_if;
  import controle_sequencia_pkg::*;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] jogada;
  logic              jogada_valida;

  modport master (output mem_address, input mem_data, input jogada, input jogada_valida);
  modport slave  (input mem_address, output mem_data, output jogada, output jogada_valida);
endinterface

// File: rtl/controle_sequencia_tempo.sv
// Loadable down-counter shared by the show and pause intervals; holds at zero.
module contador_tempo #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carrega,
  input  logic [W-1:0] valor,
  output logic         fim
);
  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge reset)
    if (!reset)              cnt <= '0;
    else if (carrega)        cnt <= valor;
    else if (cnt != '0)      cnt <= cnt - 1'b1;

  assign fim = (cnt == '0);
endmodule

// File: rtl/controle_sequencia.sv
// Memory-game sequencer: plays ROM positions 0..limite on the LEDs, then
// collects one move per position and compares it against the same ROM entry.
module controle_sequencia
  import controle_sequencia_pkg::*;
#(
  parameter int T_MOSTRA = T_MOSTRA_DEF,
  parameter int T_PAUSA  = T_PAUSA_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     iniciar,
  input  logic [IDX_W-1:0]         limite,
  controle_sequencia_if.master     bus,
  output logic [DATA_W-1:0]        leds,
  output logic                     aguardando,
  output logic                     acertou,
  output logic                     errou,
  output logic                     pronto,
  output logic [2:0]               estado
);
  localparam int TMAX = (T_MOSTRA > T_PAUSA) ? T_MOSTRA : T_PAUSA;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  estado_t           st;
  logic [IDX_W-1:0]  idx, lim;
  logic [DATA_W-1:0] reg_jogada;
  logic              show_q;
  logic              carrega, fim;
  logic [TW-1:0]     valor;

  always_comb begin
    carrega = 1'b0;
    valor   = '0;
    case (st)
      S_BUSCA_MOSTRA: begin carrega = 1'b1; valor = TW'(T_MOSTRA - 1); end
      S_MOSTRA:       if (fim) begin carrega = 1'b1; valor = TW'(T_PAUSA - 1); end
      default: ;
    endcase
  end

  contador_tempo #(.W(TW)) u_tempo (
    .clock   (clock),
    .reset   (reset),
    .carrega (carrega),
    .valor   (valor),
    .fim     (fim)
  );

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      st              <= S_INICIAL;
      idx             <= '0;
      lim             <= '0;
      reg_jogada      <= '0;
      bus.mem_address <= onehot('0);
      show_q          <= 1'b0;
      aguardando      <= 1'b0;
      acertou         <= 1'b0;
      errou           <= 1'b0;
      pronto          <= 1'b0;
    end else begin
      case (st)
        S_INICIAL, S_FIM:
          if (iniciar) begin
            lim             <= limite;
            idx             <= '0;
            bus.mem_address <= onehot('0);
            acertou         <= 1'b0;
            errou           <= 1'b0;
            pronto          <= 1'b0;
            st              <= S_BUSCA_MOSTRA;
          end
        S_BUSCA_MOSTRA: begin
          show_q <= 1'b1;
          st     <= S_MOSTRA;
        end
        S_MOSTRA:
          if (fim) begin
            show_q <= 1'b0;
            st     <= S_PAUSA;
          end
        S_PAUSA:
          if (fim) begin
            if (idx < lim) begin
              idx             <= idx + 1'b1;
              bus.mem_address <= onehot(idx + 1'b1);
              st              <= S_BUSCA_MOSTRA;
            end else begin
              idx             <= '0;
              bus.mem_address <= onehot('0);
              aguardando      <= 1'b1;
              st              <= S_ESPERA;
            end
          end
        S_ESPERA:
          if (bus.jogada_valida) begin
            reg_jogada <= bus.jogada;
            aguardando <= 1'b0;
            st         <= S_BUSCA_CMP;
          end
        S_BUSCA_CMP: st <= S_COMPARA;
        S_COMPARA:
          if (reg_jogada != bus.mem_data) begin
            errou  <= 1'b1;
            pronto <= 1'b1;
            st     <= S_FIM;
          end else if (idx == lim) begin
            acertou <= 1'b1;
            pronto  <= 1'b1;
            st      <= S_FIM;
          end else begin
            idx             <= idx + 1'b1;
            bus.mem_address <= onehot(idx + 1'b1);
            aguardando      <= 1'b1;
            st              <= S_ESPERA;
          end
        default: st <= S_INICIAL;
      endcase
    end

  // ROM data is already a flop output, so gating it with a flop that is high
  // exactly during MOSTRA shows each pattern for the full T_MOSTRA cycles.
  assign leds   = show_q ? bus.mem_data : '0;
  assign estado = st;
endmodule

// File: tb/tb_controle_sequencia.sv
// Directed bench: synchronous one-hot ROM model beside the controller,
// T_MOSTRA=4, T_PAUSA=2, checks sampled on the falling edge.
module tb_controle_sequencia;
  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [1:0] limite;
  logic [3:0] leds;
  logic       aguardando, acertou, errou, pronto;
  logic [2:0] estado;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] rom [4];

  controle_sequencia_if bus();

  controle_sequencia #(.T_MOSTRA(4), .T_PAUSA(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .iniciar    (iniciar),
    .limite     (limite),
    .bus        (bus),
    .leds       (leds),
    .aguardando (aguardando),
    .acertou    (acertou),
    .errou      (errou),
    .pronto     (pronto),
    .estado     (estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    case (bus.mem_address)
      4'b0001: bus.mem_data <= 4'b1001;
      4'b0010: bus.mem_data <= 4'b0110;
      4'b0100: bus.mem_data <= 4'b0101;
      4'b1000: bus.mem_data <= 4'b1100;
      default: bus.mem_data <= 4'b0000;
    endcase

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " estado"},  8'(estado), 8'd0);
    chk({tag, " addr"},    8'(bus.mem_address), 8'b0001);
    chk({tag, " leds"},    8'(leds), 8'd0);
    chk({tag, " flags"},   8'({aguardando, acertou, errou, pronto}), 8'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    chk_idle("rst");
    reset = 1'b1;
    cyc();
  endtask

  task automatic start(input logic [1:0] l);
    iniciar = 1'b1;
    limite  = l;
    cyc();
    iniciar = 1'b0;
    chk("start estado", 8'(estado), 8'd1);
  endtask

  // Entered at the falling edge inside BUSCA_MOSTRA; leaves one cycle after PAUSA.
  task automatic play_check(input logic [3:0] pat, input logic [3:0] addr, input bit pulse);
    chk("busca addr", 8'(bus.mem_address), 8'(addr));
    chk("busca leds", 8'(leds), 8'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("mostra estado", 8'(estado), 8'd2);
      chk("mostra leds", 8'(leds), 8'(pat));
    end
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("pausa estado", 8'(estado), 8'd3);
      chk("pausa leds", 8'(leds), 8'd0);
      if (pulse && k == 0) begin iniciar = 1'b1; limite = 2'd3; end
      else iniciar = 1'b0;
    end
    cyc();
  endtask

  task automatic move(input logic [3:0] p);
    bus.jogada       = p;
    bus.jogada_valida = 1'b1;
    cyc();
    bus.jogada_valida = 1'b0;
    chk("busca_cmp", 8'(estado), 8'd5);
    cyc();
    chk("compara", 8'(estado), 8'd6);
    cyc();
  endtask

  initial begin
    rom[0] = 4'b1001; rom[1] = 4'b0110; rom[2] = 4'b0101; rom[3] = 4'b1100;
    reset = 1'b0; iniciar = 1'b0; limite = 2'd0;
    bus.jogada = 4'd0; bus.jogada_valida = 1'b0;
    cyc(); cyc();
    chk_idle("por");
    reset = 1'b1;
    cyc();

    // 1: asynchronous reset in the middle of MOSTRA
    start(2'd0);
    cyc(); cyc();
    chk("t1 mostra", 8'(leds), 8'b1001);
    #2 reset = 1'b0;
    #1 chk_idle("t1 async");
    cyc();
    reset = 1'b1;
    cyc();

    // 2: single-position round, then iniciar ignored in ESPERA
    start(2'd0);
    play_check(4'b1001, 4'b0001, 1'b0);
    chk("t2 estado", 8'(estado), 8'd4);
    chk("t2 aguardando", 8'(aguardando), 8'd1);
    chk("t2 addr", 8'(bus.mem_address), 8'b0001);
    iniciar = 1'b1;
    cyc();
    iniciar = 1'b0;
    chk("t2 ini ignored", 8'(estado), 8'd4);
    do_reset();

    // 3: full four-position playback
    start(2'd3);
    for (int i = 0; i < 4; i++) play_check(rom[i], 4'b0001 << i, 1'b0);
    chk("t3 estado", 8'(estado), 8'd4);
    chk("t3 addr", 8'(bus.mem_address), 8'b0001);
    do_reset();

    // 4: two correct moves
    start(2'd1);
    play_check(rom[0], 4'b0001, 1'b0);
    play_check(rom[1], 4'b0010, 1'b0);
    move(4'b1001);
    chk("t4 back espera", 8'(estado), 8'd4);
    chk("t4 addr", 8'(bus.mem_address), 8'b0010);
    move(4'b0110);
    chk("t4 estado", 8'(estado), 8'd7);
    chk("t4 flags", 8'({aguardando, acertou, errou, pronto}), 8'b0101);

    // 5: restart from FIM, strobe during playback, wrong second move
    start(2'd2);
    chk("t5 cleared", 8'({acertou, errou, pronto}), 8'd0);
    bus.jogada = 4'b1001;
    bus.jogada_valida = 1'b1;
    play_check(rom[0], 4'b0001, 1'b0);
    bus.jogada_valida = 1'b0;
    play_check(rom[1], 4'b0010, 1'b0);
    play_check(rom[2], 4'b0100, 1'b0);
    chk("t5 espera", 8'(estado), 8'd4);
    move(4'b1001);
    chk("t5 back espera", 8'(estado), 8'd4);
    move(4'b0101);
    chk("t5 estado", 8'(estado), 8'd7);
    chk("t5 flags", 8'({aguardando, acertou, errou, pronto}), 8'b0011);

    // 6: iniciar (and limite change) in PAUSA ignored; iniciar in FIM restarts
    start(2'd1);
    play_check(rom[0], 4'b0001, 1'b1);
    chk("t6 no restart", 8'(estado), 8'd1);
    play_check(rom[1], 4'b0010, 1'b0);
    chk("t6 espera", 8'(estado), 8'd4);
    move(4'b1001);
    move(4'b0110);
    chk("t6 fim", 8'({estado, acertou, errou, pronto}), 8'({3'd7, 3'b101}));
    start(2'd0);
    chk("t6 cleared", 8'({acertou, errou, pronto}), 8'd0);
    play_check(4'b1001, 4'b0001, 1'b0);
    chk("t6 espera2", 8'(estado), 8'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
